// File: rtl/rect_list_gather_pkg.sv
// Shared types and sizing for the rect list gather block.
// The slot count N is 4.
// POSITION_WIDTH is fixed at 8, so one box {x1,y1,x2,y2} is 32 bits.
// Possibility is 4 bits; a value of 0 marks an empty slot.
package rect_list_gather_pkg;

    localparam int unsigned N        = 4;
    localparam int unsigned P_W      = 8;
    localparam int unsigned BOX_W    = 4 * P_W;
    localparam int unsigned R_W      = 4;
    localparam int unsigned POSI_MIN = 1;
    localparam int unsigned CNT_W    = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_PUBLISH = 2'd1,
        S_START   = 2'd2
    } state_t;

    // One stored detection.
    typedef struct packed {
        logic [BOX_W-1:0] head;
        logic [BOX_W-1:0] hair;
        logic [R_W-1:0]   posi;
    } rect_t;

endpackage

// File: rtl/rect_box_normalize.sv
// Orders one box so that x1<=x2 and y1<=y2.
// Ports:
//   box     in   BOX_W   {x1,y1,x2,y2}, x1 in the MSBs
//   norm_c  out  BOX_W   the same box with each coordinate pair ordered (combinational)
module rect_box_normalize
    import rect_list_gather_pkg::*;
(
    input  logic [BOX_W-1:0] box,
    output logic [BOX_W-1:0] norm_c
);

    logic [P_W-1:0] x1;
    logic [P_W-1:0] y1;
    logic [P_W-1:0] x2;
    logic [P_W-1:0] y2;

    assign {x1, y1, x2, y2} = box;

    // The x pair and the y pair are swapped independently of each other.
    always_comb begin
        norm_c = {(x1 > x2) ? x2 : x1,
                  (y1 > y2) ? y2 : y1,
                  (x1 > x2) ? x1 : x2,
                  (y1 > y2) ? y1 : y2};
    end

endmodule

// File: rtl/rect_list_gather.sv
// Gathers per-frame detections into a slot bank. At each rising edge of
// i_vs it publishes the bank as packed lists and pulses o_start once.
// Optional macro RECT_LIST_SORT_EN: keep the bank sorted by posi, highest
// first. A new entry goes after existing entries of equal posi. When the
// bank is full, the lowest entry is evicted.
// Ports:
//   sys_clk, sys_rst   clock; synchronous active-high reset
//   i_vs               frame sync; a rising edge closes the frame
//   i_det_valid/o_det_ready, i_det_head, i_det_hair, i_det_posi
//                      detection handshake and payload
//   o_head_wire, o_hair_wire, o_posi_wire
//                      published lists; slot k is at [k*W +: W]
//   o_count            number of rects published
//   o_start            one-cycle pulse after a new list becomes visible
//   o_overflow         the published frame lost at least one detection
module rect_list_gather
    import rect_list_gather_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               i_vs,
    input  logic               i_det_valid,
    output logic               o_det_ready,
    input  logic [BOX_W-1:0]   i_det_head,
    input  logic [BOX_W-1:0]   i_det_hair,
    input  logic [R_W-1:0]     i_det_posi,
    output logic [N*BOX_W-1:0] o_head_wire,
    output logic [N*BOX_W-1:0] o_hair_wire,
    output logic [N*R_W-1:0]   o_posi_wire,
    output logic [7:0]         o_count,
    output logic               o_start,
    output logic               o_overflow
);

    state_t           state;
    state_t           state_next;
    logic             vs_q;
    logic             vs_rise;
    rect_t            bank      [N];
    rect_t            bank_next [N];
    rect_t            shift_src [N];
    logic [CNT_W-1:0] wr_cnt;
    logic             ovf_pend;
    logic [CNT_W-1:0] ins_pos;
    logic             accept;
    logic             full;
    rect_t            new_rect;
    logic [BOX_W-1:0] head_norm;
    logic [BOX_W-1:0] hair_norm;

    rect_box_normalize u_norm_head (.box(i_det_head), .norm_c(head_norm));
    rect_box_normalize u_norm_hair (.box(i_det_hair), .norm_c(hair_norm));

    assign vs_rise = i_vs & ~vs_q;
    assign full    = (wr_cnt == CNT_W'(N));
    // Detections below the posi threshold are consumed but are not stored.
    assign accept  = (state == S_COLLECT) && i_det_valid && (i_det_posi >= R_W'(POSI_MIN));

    always_comb begin
        new_rect      = '0;
        new_rect.head = head_norm;
        new_rect.hair = hair_norm;
        new_rect.posi = i_det_posi;
    end

    // Select the insert slot. A value of N means the detection is dropped.
    always_comb begin
        ins_pos = '0;
`ifdef RECT_LIST_SORT_EN
        // Empty slots hold posi 0, which never reaches POSI_MIN.
        // Counting the entries >= new posi therefore places the new entry
        // after any equal entries. If the bank is full and every entry is
        // >= the new posi, the count is N and the detection is dropped.
        for (int k = 0; k < N; k++) begin
            if (bank[k].posi >= i_det_posi) begin
                ins_pos = ins_pos + CNT_W'(1);
            end
        end
`else
        ins_pos = wr_cnt;
`endif
    end

    // Insert network: slots below ins_pos keep their value, the new entry
    // goes to ins_pos, and slots above it take the entry one slot up.
    // Without sorting, everything above wr_cnt is zero, so the shift
    // leaves those slots unchanged.
    always_comb begin
        shift_src[0] = '0;
        for (int k = 1; k < N; k++) begin
            shift_src[k] = bank[k-1];
        end
        for (int k = 0; k < N; k++) begin
            bank_next[k] = bank[k];
            if (CNT_W'(k) == ins_pos) begin
                bank_next[k] = new_rect;
            end else if (CNT_W'(k) > ins_pos) begin
                bank_next[k] = shift_src[k];
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_COLLECT: if (vs_rise) state_next = S_PUBLISH;
            S_PUBLISH: state_next = S_START;
            S_START:   state_next = S_COLLECT;
            default:   state_next = S_COLLECT;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= S_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // Bank, edge detector and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vs_q        <= 1'b0;
            wr_cnt      <= '0;
            ovf_pend    <= 1'b0;
            o_det_ready <= 1'b1;
            o_start     <= 1'b0;
            o_count     <= '0;
            o_overflow  <= 1'b0;
            o_head_wire <= '0;
            o_hair_wire <= '0;
            o_posi_wire <= '0;
            for (int k = 0; k < N; k++) begin
                bank[k] <= '0;
            end
        end else begin
            vs_q        <= i_vs;
            o_det_ready <= (state_next == S_COLLECT);
            o_start     <= (state_next == S_START);
            if (state == S_PUBLISH) begin
                for (int k = 0; k < N; k++) begin
                    o_head_wire[k*BOX_W +: BOX_W] <= bank[k].head;
                    o_hair_wire[k*BOX_W +: BOX_W] <= bank[k].hair;
                    o_posi_wire[k*R_W +: R_W]     <= bank[k].posi;
                    bank[k]                       <= '0;
                end
                o_count    <= 8'(wr_cnt);
                o_overflow <= ovf_pend;
                wr_cnt     <= '0;
                ovf_pend   <= 1'b0;
            end else if (accept) begin
                if (ins_pos < CNT_W'(N)) begin
                    for (int k = 0; k < N; k++) begin
                        bank[k] <= bank_next[k];
                    end
                end
                if (full) begin
                    ovf_pend <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rect_list_gather.sv
module tb_rect_list_gather;
    import rect_list_gather_pkg::*;

    logic               sys_clk = 1'b0;
    logic               sys_rst;
    logic               i_vs;
    logic               i_det_valid;
    logic               o_det_ready;
    logic [BOX_W-1:0]   i_det_head;
    logic [BOX_W-1:0]   i_det_hair;
    logic [R_W-1:0]     i_det_posi;
    logic [N*BOX_W-1:0] o_head_wire;
    logic [N*BOX_W-1:0] o_hair_wire;
    logic [N*R_W-1:0]   o_posi_wire;
    logic [7:0]         o_count;
    logic               o_start;
    logic               o_overflow;

    rect_list_gather dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .i_vs(i_vs),
        .i_det_valid(i_det_valid), .o_det_ready(o_det_ready),
        .i_det_head(i_det_head), .i_det_hair(i_det_hair), .i_det_posi(i_det_posi),
        .o_head_wire(o_head_wire), .o_hair_wire(o_hair_wire), .o_posi_wire(o_posi_wire),
        .o_count(o_count), .o_start(o_start), .o_overflow(o_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    rect_t cur_q[$];
    rect_t exp_bank[N];
    int    exp_count;
    bit    exp_ovf;
    bit    exp_start;
    bit    exp_ready;
    int    busy;
    bit    vs_prev;
    bit    model_live = 1'b0;

    function automatic logic [31:0] norm(input logic [31:0] b);
        logic [7:0] x1, y1, x2, y2;
        {x1, y1, x2, y2} = b;
        return {(x1 < x2 ? x1 : x2), (y1 < y2 ? y1 : y2),
                (x1 < x2 ? x2 : x1), (y1 < y2 ? y2 : y1)};
    endfunction

    // The published list is every accepted detection of the frame,
    // optionally stable-sorted by posi (highest first), truncated to N.
    function automatic void publish();
        rect_t list[$];
        list = cur_q;
`ifdef RECT_LIST_SORT_EN
        for (int i = 1; i < list.size(); i++) begin
            rect_t t = list[i];
            int    j = i;
            while (j > 0 && list[j-1].posi < t.posi) begin
                list[j] = list[j-1];
                j--;
            end
            list[j] = t;
        end
`endif
        for (int k = 0; k < N; k++) exp_bank[k] = (k < list.size()) ? list[k] : '0;
        exp_count = (list.size() > N) ? N : list.size();
        exp_ovf   = (list.size() > N);
        cur_q.delete();
    endfunction

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            cur_q.delete();
            for (int k = 0; k < N; k++) exp_bank[k] = '0;
            exp_count = 0; exp_ovf = 0; exp_start = 0; exp_ready = 1;
            busy = 0; vs_prev = 0; model_live = 1'b1;
        end else if (model_live) begin
            bit rise;
            rise    = i_vs && !vs_prev;
            vs_prev = i_vs;
            exp_start = 0;
            if (busy == 0) begin
                if (i_det_valid && i_det_posi >= POSI_MIN) begin
                    rect_t r;
                    r.head = norm(i_det_head);
                    r.hair = norm(i_det_hair);
                    r.posi = i_det_posi;
                    cur_q.push_back(r);
                end
                if (rise) busy = 2;
            end else if (busy == 2) begin
                publish();
                exp_start = 1;
                busy = 1;
            end else begin
                busy = 0;
            end
            exp_ready = (busy == 0);
        end
    end

    // Compare DUT against the model every cycle.
    always @(negedge sys_clk) begin
        if (model_live) begin
            chk("ready", 64'(o_det_ready), 64'(exp_ready));
            chk("start", 64'(o_start), 64'(exp_start));
            chk("count", 64'(o_count), 64'(exp_count));
            chk("overflow", 64'(o_overflow), 64'(exp_ovf));
            for (int k = 0; k < N; k++) begin
                chk($sformatf("head[%0d]", k), 64'(o_head_wire[k*BOX_W +: BOX_W]), 64'(exp_bank[k].head));
                chk($sformatf("hair[%0d]", k), 64'(o_hair_wire[k*BOX_W +: BOX_W]), 64'(exp_bank[k].hair));
                chk($sformatf("posi[%0d]", k), 64'(o_posi_wire[k*R_W +: R_W]), 64'(exp_bank[k].posi));
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [31:0] h, input logic [31:0] hr, input logic [3:0] p);
        bit acc;
        int n;
        i_det_valid = 1'b1; i_det_head = h; i_det_hair = hr; i_det_posi = p;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = o_det_ready;
            @(negedge sys_clk);
            n++;
        end
        if (!acc) chk("send_timeout", 64'(0), 64'(1));
        i_det_valid = 1'b0;
    endtask

    // Raise vs; returns at the negedge inside S_START.
    task automatic vs_publish();
        i_vs = 1'b1;
        @(negedge sys_clk);
        i_vs = 1'b0;
        @(negedge sys_clk);
    endtask

    function automatic logic [3:0] slot_posi(input int k);
        return o_posi_wire[k*R_W +: R_W];
    endfunction

    initial begin
        logic [63:0] exp_h;
        sys_rst = 1'b1; i_vs = 1'b0; i_det_valid = 1'b0;
        i_det_head = '0; i_det_hair = '0; i_det_posi = '0;
        repeat (2) @(negedge sys_clk);
        chk("lit_reset_ready", 64'(o_det_ready), 64'(1));
        chk("lit_reset_count", 64'(o_count), 64'(0));
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // 1: three detections, published in arrival order (or sorted).
        send(32'h01020304, 32'h05060708, 4'd5);
        send(32'h10203040, 32'h11223344, 4'd9);
        send(32'h0A0B0C0D, 32'h01010202, 4'd2);
        i_vs = 1'b1;
        @(negedge sys_clk);
        i_vs = 1'b0;
        chk("lit_t1_start_early", 64'(o_start), 64'(0));
        @(negedge sys_clk);
        chk("lit_t1_start", 64'(o_start), 64'(1));
        chk("lit_t1_count", 64'(o_count), 64'(3));
`ifdef RECT_LIST_SORT_EN
        chk("lit_t1_posi0", 64'(slot_posi(0)), 64'(9));
        chk("lit_t1_posi1", 64'(slot_posi(1)), 64'(5));
`else
        chk("lit_t1_posi0", 64'(slot_posi(0)), 64'(5));
        chk("lit_t1_posi1", 64'(slot_posi(1)), 64'(9));
`endif
        chk("lit_t1_posi2", 64'(slot_posi(2)), 64'(2));
        if (N > 3) chk("lit_t1_posi3", 64'(slot_posi(3)), 64'(0));
        @(negedge sys_clk);

        // 2: N+2 detections overflow; the next frame clears the flag.
        for (int i = 0; i < N + 2; i++) send(32'h01010202 + 32'(i), 32'h00000101, 4'(i + 1));
        vs_publish();
        chk("lit_t2_count", 64'(o_count), 64'(N));
        chk("lit_t2_ovf", 64'(o_overflow), 64'(1));
        @(negedge sys_clk);
        send(32'h01020304, 32'h01020304, 4'd3);
        vs_publish();
        chk("lit_t2b_ovf", 64'(o_overflow), 64'(0));
        chk("lit_t2b_count", 64'(o_count), 64'(1));
        @(negedge sys_clk);

        // 3: normalisation; a posi-0 detection is discarded silently.
        send({8'd20, 8'd30, 8'd10, 8'd5}, {8'd50, 8'd40, 8'd60, 8'd10}, 4'd4);
        send(32'h01020304, 32'h01020304, 4'd0);
        vs_publish();
        chk("lit_t3_count", 64'(o_count), 64'(1));
        exp_h = 64'({8'd10, 8'd5, 8'd20, 8'd30});
        chk("lit_t3_head", 64'(o_head_wire[BOX_W-1:0]), exp_h);
        exp_h = 64'({8'd50, 8'd10, 8'd60, 8'd40});
        chk("lit_t3_hair", 64'(o_hair_wire[BOX_W-1:0]), exp_h);
        chk("lit_t3_ovf", 64'(o_overflow), 64'(0));
        @(negedge sys_clk);

        // 4: a detection in the vs_rise cycle belongs to the closing frame.
        //    A detection offered during publish is held until the next frame.
        send(32'h01020304, 32'h01020304, 4'd7);
        i_vs = 1'b1;
        send(32'h02030405, 32'h02030405, 4'd8);
        i_vs = 1'b0;
        send(32'h03040506, 32'h03040506, 4'd6);
        chk("lit_t4_count", 64'(o_count), 64'(2));
        vs_publish();
        chk("lit_t4b_count", 64'(o_count), 64'(1));
        chk("lit_t4b_posi0", 64'(slot_posi(0)), 64'(6));
        @(negedge sys_clk);

        // 5: reset mid-frame discards the partial bank; an empty frame still pulses.
        send(32'h01020304, 32'h01020304, 4'd5);
        send(32'h01020304, 32'h01020304, 4'd6);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("lit_t5_count", 64'(o_count), 64'(0));
        chk("lit_t5_posi0", 64'(slot_posi(0)), 64'(0));
        chk("lit_t5_start", 64'(o_start), 64'(0));
        repeat (3) @(negedge sys_clk);
        vs_publish();
        chk("lit_t5b_start", 64'(o_start), 64'(1));
        chk("lit_t5b_count", 64'(o_count), 64'(0));
        @(negedge sys_clk);

        // A second vs rise during publish/start must not cause another publish.
        send(32'h01020304, 32'h01020304, 4'd2);
        i_vs = 1'b1; @(negedge sys_clk);
        i_vs = 1'b0; @(negedge sys_clk);
        i_vs = 1'b1; @(negedge sys_clk);
        i_vs = 1'b0;
        repeat (4) @(negedge sys_clk);
        chk("lit_glitch_count", 64'(o_count), 64'(1));

        // 6: posi 3,7,7,1,9, with distinct heads to check the order of equal entries.
        send(32'h00000003, 32'h0, 4'd3);
        send(32'h00000071, 32'h0, 4'd7);
        send(32'h00000072, 32'h0, 4'd7);
        send(32'h00000001, 32'h0, 4'd1);
        send(32'h00000009, 32'h0, 4'd9);
        vs_publish();
        chk("lit_t6_ovf", 64'(o_overflow), 64'(N <= 4));
        if (N == 4) begin
`ifdef RECT_LIST_SORT_EN
            chk("lit_t6_posi0", 64'(slot_posi(0)), 64'(9));
            chk("lit_t6_posi3", 64'(slot_posi(3)), 64'(3));
            chk("lit_t6_head1", 64'(o_head_wire[BOX_W +: BOX_W]), 64'(32'h00000071));
            chk("lit_t6_head2", 64'(o_head_wire[2*BOX_W +: BOX_W]), 64'(32'h00000072));
`else
            chk("lit_t6_posi0", 64'(slot_posi(0)), 64'(3));
            chk("lit_t6_posi3", 64'(slot_posi(3)), 64'(1));
`endif
        end
        repeat (3) @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
